// File: rtl/che_hist_excess_calc.sv
// che_hist_excess_calc
// CLAHE clip stage: latches one tile histogram and a clip limit, then scans the
// bins PAR per cycle. Each bin is clamped to the limit and the removed counts
// are summed. The clipped histogram and the saturated total excess are
// presented together for one cycle (vld_o) and held until the next job.
module che_hist_excess_calc #(
  parameter int GRAY_LEVEAL = 256,
  parameter int HIST_BIN_WD = 16,
  parameter int PAR         = 4,
  parameter int EXCESS_WD   = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               vld_i,
  input  logic [HIST_BIN_WD-1:0]             clip_limit_i,
  input  logic [GRAY_LEVEAL*HIST_BIN_WD-1:0] hist_i,
  output logic                               busy_o,
  output logic                               vld_o,
  output logic [GRAY_LEVEAL*HIST_BIN_WD-1:0] hist_o,
  output logic [EXCESS_WD-1:0]               express_bin_o
);

  localparam int NGRP       = GRAY_LEVEAL / PAR;
  localparam int IDX_WD     = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int BIN_IDX_WD = (GRAY_LEVEAL > 1) ? $clog2(GRAY_LEVEAL) : 1;
  localparam int ACC_WD     = HIST_BIN_WD + BIN_IDX_WD;
  localparam int GSUM_WD    = HIST_BIN_WD + ((PAR > 1) ? $clog2(PAR) : 1) + 1;
  localparam int LAST_BASE  = (NGRP - 1) * PAR;
  localparam logic [IDX_WD-1:0] LAST_IDX = IDX_WD'(NGRP - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_r;
  logic [HIST_BIN_WD-1:0]  buf_r [GRAY_LEVEAL];
  logic [HIST_BIN_WD-1:0]  limit_r;
  logic [IDX_WD-1:0]       idx_r;
  logic [ACC_WD-1:0]       acc_r;

  logic [BIN_IDX_WD-1:0]   bin_idx_s  [PAR];
  logic [HIST_BIN_WD-1:0]  grp_clip_s [PAR];
  logic [GSUM_WD-1:0]      grp_excess_s;
  logic [ACC_WD-1:0]       acc_next_s;

  // Total excess clamped to the output range; acc itself never wraps.
  function automatic logic [EXCESS_WD-1:0] sat_excess(input logic [ACC_WD-1:0] a);
    logic [EXCESS_WD-1:0] r;
    if ((a >> EXCESS_WD) != {ACC_WD{1'b0}}) begin
      r = {EXCESS_WD{1'b1}};
    end else begin
      r = a[EXCESS_WD-1:0];
    end
    return r;
  endfunction

  // Clamp the current group of PAR bins and sum what was cut off.
  always_comb begin
    grp_excess_s = {GSUM_WD{1'b0}};
    for (int p = 0; p < PAR; p++) begin
      bin_idx_s[p] = BIN_IDX_WD'(int'(idx_r) * PAR + p);
      if (buf_r[bin_idx_s[p]] > limit_r) begin
        grp_clip_s[p] = limit_r;
        grp_excess_s  = grp_excess_s + GSUM_WD'(buf_r[bin_idx_s[p]] - limit_r);
      end else begin
        grp_clip_s[p] = buf_r[bin_idx_s[p]];
      end
    end
    acc_next_s = acc_r + ACC_WD'(grp_excess_s);
  end

  // Working buffer: loaded on an accepted start, rewritten group by group while scanning.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == ST_IDLE) && vld_i) begin
      for (int k = 0; k < GRAY_LEVEAL; k++) begin
        buf_r[k] <= hist_i[k*HIST_BIN_WD +: HIST_BIN_WD];
      end
    end else if (!rst && (state_r == ST_SCAN)) begin
      for (int p = 0; p < PAR; p++) begin
        buf_r[bin_idx_s[p]] <= grp_clip_s[p];
      end
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      busy_o        <= 1'b0;
      vld_o         <= 1'b0;
      hist_o        <= {(GRAY_LEVEAL*HIST_BIN_WD){1'b0}};
      express_bin_o <= {EXCESS_WD{1'b0}};
      acc_r         <= {ACC_WD{1'b0}};
      idx_r         <= {IDX_WD{1'b0}};
      limit_r       <= {HIST_BIN_WD{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          vld_o <= 1'b0;
          if (vld_i) begin
            limit_r <= clip_limit_i;
            acc_r   <= {ACC_WD{1'b0}};
            idx_r   <= {IDX_WD{1'b0}};
            busy_o  <= 1'b1;
            state_r <= ST_SCAN;
          end else begin
            busy_o  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + IDX_WD'(1);
          if (idx_r == LAST_IDX) begin
            // The last group is still in flight, so merge its clipped bins
            // straight into the result instead of waiting for the buffer.
            for (int k = 0; k < GRAY_LEVEAL; k++) begin
              hist_o[k*HIST_BIN_WD +: HIST_BIN_WD] <= buf_r[k];
            end
            for (int p = 0; p < PAR; p++) begin
              hist_o[(LAST_BASE+p)*HIST_BIN_WD +: HIST_BIN_WD] <= grp_clip_s[p];
            end
            express_bin_o <= sat_excess(acc_next_s);
            vld_o         <= 1'b1;
            state_r       <= ST_DONE;
          end else begin
            state_r <= ST_SCAN;
          end
        end
        ST_DONE: begin
          vld_o   <= 1'b0;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          vld_o   <= 1'b0;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
